// File: rtl/i8254_pkg.sv
// Shared constants for the 8254 counter access stage.
// RW encodings, mode values, status bit positions and control-word field slices.
package i8254_pkg;

    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB   = 2'b01;
    localparam logic [1:0] RW_MSB   = 2'b10;
    localparam logic [1:0] RW_BOTH  = 2'b11;

    localparam logic [2:0] MODE_0 = 3'd0;
    localparam logic [2:0] MODE_1 = 3'd1;
    localparam logic [2:0] MODE_2 = 3'd2;
    localparam logic [2:0] MODE_3 = 3'd3;
    localparam logic [2:0] MODE_4 = 3'd4;
    localparam logic [2:0] MODE_5 = 3'd5;

    // status byte layout: {out, null_count, rw[1:0], mode[2:0], bcd}
    localparam int ST_OUT  = 7;
    localparam int ST_NULL = 6;
    localparam int ST_RW   = 4;
    localparam int ST_MODE = 1;
    localparam int ST_BCD  = 0;

    // control-word fields
    localparam int CW_SC_HI   = 7;
    localparam int CW_SC_LO   = 6;
    localparam int CW_RW_HI   = 5;
    localparam int CW_RW_LO   = 4;
    localparam int CW_MODE_HI = 3;
    localparam int CW_MODE_LO = 1;
    localparam int CW_BCD     = 0;

    // read-back command fields
    localparam int RB_NCOUNT  = 5;
    localparam int RB_NSTATUS = 4;
    localparam int RB_SEL     = 1;

    function automatic logic [7:0] pick_byte(input logic [15:0] v, input logic hi);
        return hi ? v[15:8] : v[7:0];
    endfunction

endpackage

// File: rtl/i8254_output_latch.sv
// Output latch for one 8254 counter: count latch, status latch and read byte sequencer.
// Ports: clk, rst, clr (reprogram), rd_en, rw, cnt_req, sts_req, count_live, status -> dout.
module i8254_output_latch
    import i8254_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        rd_en,
    input  logic [1:0]  rw,
    input  logic        cnt_req,
    input  logic        sts_req,
    input  logic [15:0] count_live,
    input  logic [7:0]  status,
    output logic [7:0]  dout
);

    logic [15:0] cnt_q;
    logic        cnt_full;
    logic [7:0]  sts_q;
    logic        sts_full;
    logic        rd_ff;

    logic [15:0] src;
    logic        hi;
    logic        last;

    always_comb begin
        src  = cnt_full ? cnt_q : count_live;
        hi   = (rw == RW_MSB) || ((rw == RW_BOTH) && rd_ff);
        last = (rw != RW_BOTH) || rd_ff;
    end

    // capture tests pre-edge emptiness, so a read that frees the latch
    // in the same cycle does not also let a new capture in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            cnt_full <= 1'b0;
            sts_q    <= '0;
            sts_full <= 1'b0;
            rd_ff    <= 1'b0;
            dout     <= '0;
        end else begin
            if (rd_en) begin
                if (sts_full) begin
                    dout     <= sts_q;
                    sts_full <= 1'b0;
                end else begin
                    dout <= pick_byte(src, hi);
                    if (rw == RW_BOTH) rd_ff <= ~rd_ff;
                    if (last) cnt_full <= 1'b0;
                end
            end
            if (cnt_req && !cnt_full) begin
                cnt_q    <= count_live;
                cnt_full <= 1'b1;
            end
            if (sts_req && !sts_full) begin
                sts_q    <= status;
                sts_full <= 1'b1;
            end
            if (clr) begin
                cnt_full <= 1'b0;
                sts_full <= 1'b0;
                rd_ff    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i8254_count_access.sv
// CPU access stage of one 8254 counter: control word decode, count byte assembly, load strobe.
// Ports: clk, rst, wr_en, ctrl_en, rd_en, din, count_live, out_pin, count_ack ->
//   msb, lsb, load, mode, bcd, dout. Define I8254_READBACK_EN for the read-back command.
module i8254_count_access
    import i8254_pkg::*;
#(
    parameter logic [2:0] RST_MODE = 3'd0,
    parameter logic [1:0] RST_RW   = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        ctrl_en,
    input  logic        rd_en,
    input  logic [7:0]  din,
    input  logic [15:0] count_live,
    input  logic        out_pin,
    input  logic        count_ack,
    output logic [7:0]  msb,
    output logic [7:0]  lsb,
    output logic        load,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic [7:0]  dout
);

    logic [1:0] rw;
    logic       wr_ff;
    logic       null_count;

    logic [1:0] cw_rw;
    logic       is_rb;
    logic       prog;
    logic       wr_go;
    logic       cnt_req;
    logic       sts_req;
    logic [7:0] status;

    always_comb begin
        cw_rw  = din[CW_RW_HI:CW_RW_LO];
        is_rb  = (din[CW_SC_HI:CW_SC_LO] == 2'b11);
        prog   = ctrl_en && !is_rb && (cw_rw != RW_LATCH);
        wr_go  = wr_en && !ctrl_en;
        status = {out_pin, null_count, rw, mode, bcd};
`ifdef I8254_READBACK_EN
        cnt_req = ctrl_en && ((!is_rb && (cw_rw == RW_LATCH))
                  || (is_rb && din[RB_SEL] && !din[RB_NCOUNT]));
        sts_req = ctrl_en && is_rb && din[RB_SEL] && !din[RB_NSTATUS];
`else
        cnt_req = ctrl_en && !is_rb && (cw_rw == RW_LATCH);
        sts_req = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb        <= '0;
            lsb        <= '0;
            load       <= 1'b0;
            mode       <= RST_MODE;
            rw         <= RST_RW;
            bcd        <= 1'b0;
            wr_ff      <= 1'b0;
            null_count <= 1'b1;
        end else begin
            load <= 1'b0;
            if (prog) begin
                rw         <= cw_rw;
                mode       <= din[CW_MODE_HI:CW_MODE_LO];
                bcd        <= din[CW_BCD];
                wr_ff      <= 1'b0;
                null_count <= 1'b1;
            end else if (wr_go) begin
                null_count <= 1'b1;
                unique case (rw)
                    RW_LSB: begin
                        lsb  <= din;
                        msb  <= '0;
                        load <= 1'b1;
                    end
                    RW_MSB: begin
                        msb  <= din;
                        lsb  <= '0;
                        load <= 1'b1;
                    end
                    RW_BOTH: begin
                        if (!wr_ff) begin
                            lsb   <= din;
                            wr_ff <= 1'b1;
                        end else begin
                            msb   <= din;
                            wr_ff <= 1'b0;
                            load  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (count_ack) begin
                null_count <= 1'b0;
            end
        end
    end

    i8254_output_latch u_latch (
        .clk        (clk),
        .rst        (rst),
        .clr        (prog),
        .rd_en      (rd_en),
        .rw         (rw),
        .cnt_req    (cnt_req),
        .sts_req    (sts_req),
        .count_live (count_live),
        .status     (status),
        .dout       (dout)
    );

endmodule
